spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_half_tick.sv | 43 ++++
 rtl/spi_master.sv | 145 ++++++++++++++
 tb/tb_spi_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM encoding, mode constants
// and counter-width helpers.
package spi_pkg;

    localparam int SPI_CPOL = 0;
    localparam int SPI_CPHA = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4
    } spi_state_e;

    // Width of a counter spanning 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold the value n itself.
    function automatic int bitcnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: counts 0..CLK_DIV-1 while enabled and flags the last
// count, which is the cycle on which the FSM changes phase.
module spi_half_tick
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic wrap_o
);

    localparam int CW = cnt_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    // Wrap detection and next count.
    always_comb begin
        wrap  = en_i && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap_o = wrap;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: sends one BITS-wide word MSB-first on mosi while
// capturing miso, with sclk/ss_n derived from clk via CLK_DIV.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned BITS    = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] tx_data,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] rx_data,
    output logic            sclk,
    output logic            ss_n,
    output logic            mosi,
    input  logic            miso
);

    localparam int BW = bitcnt_w(BITS);

    spi_state_e      state_q, state_d;
    logic [BITS-1:0] tx_q, tx_d;
    logic [BITS-1:0] rxsr_q, rxsr_d;
    logic [BITS-1:0] rx_q, rx_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            sclk_q, sclk_d;
    logic            ss_n_q, ss_n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wrap;

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (state_q != IDLE),
        .clr_i  (state_q == IDLE),
        .wrap_o (wrap)
    );

    // Phase sequencing; mosi is the MSB of tx_q, so the shift register is
    // held on the last bit and cleared on exit to give mosi=0 while idle.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rxsr_d  = rxsr_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        ss_n_d  = ss_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    tx_d    = tx_data;
                    rxsr_d  = '0;
                    bit_d   = BW'(BITS);
                    ss_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                end
            end
            SETUP: begin
                if (wrap) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                    rxsr_d  = {rxsr_q[BITS-2:0], miso};
                end
            end
            HIGH: begin
                if (wrap) begin
                    state_d = LOW;
                    sclk_d  = 1'b0;
                    bit_d   = bit_q - BW'(1);
                    if (bit_q != BW'(1)) begin
                        tx_d = {tx_q[BITS-2:0], 1'b0};
                    end
                end
            end
            LOW: begin
                if (wrap) begin
                    if (bit_q == '0) begin
                        state_d = HOLD;
                    end else begin
                        state_d = HIGH;
                        sclk_d  = 1'b1;
                        rxsr_d  = {rxsr_q[BITS-2:0], miso};
                    end
                end
            end
            HOLD: begin
                if (wrap) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rx_d    = rxsr_q;
                    ss_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    tx_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rxsr_q  <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rxsr_q  <= rxsr_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            ss_n_q  <= ss_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign sclk    = sclk_q;
    assign ss_n    = ss_n_q;
    assign mosi    = tx_q[BITS-1];

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: instance A (BITS=8, CLK_DIV=2) and
// instance B (BITS=8, CLK_DIV=1), with loopback and a mode-0 slave model.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- instance A: CLK_DIV=2 ----------------
    logic       a_rst = 1'b1, a_start = 1'b0, a_mode = 1'b0;
    logic [7:0] a_tx = '0, a_rx;
    logic       a_busy, a_done, a_sclk, a_ss_n, a_mosi, a_miso;
    logic [7:0] slv_sr = '0, slv_rx = '0;

    assign a_miso = a_mode ? slv_sr[7] : a_mosi;

    spi_master #(.BITS(8), .CLK_DIV(2)) u_dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .tx_data(a_tx),
        .busy(a_busy), .done(a_done), .rx_data(a_rx),
        .sclk(a_sclk), .ss_n(a_ss_n), .mosi(a_mosi), .miso(a_miso)
    );

    // ---------------- instance B: CLK_DIV=1 ----------------
    logic       b_rst = 1'b1, b_start = 1'b0;
    logic [7:0] b_tx = '0, b_rx;
    logic       b_busy, b_done, b_sclk, b_ss_n, b_mosi;

    spi_master #(.BITS(8), .CLK_DIV(1)) u_dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .tx_data(b_tx),
        .busy(b_busy), .done(b_done), .rx_data(b_rx),
        .sclk(b_sclk), .ss_n(b_ss_n), .mosi(b_mosi), .miso(b_mosi)
    );

    // ---------------- scoreboards ----------------
    logic [7:0]  qa_rx[$];
    int unsigned qa_cyc[$];
    logic [7:0]  qb_rx[$];
    int unsigned qb_cyc[$];

    int unsigned a_done_cnt = 0, a_rises = 0;
    int unsigned b_done_cnt = 0;
    logic        a_mosi_seq[$];
    logic        b_sclk_seq[$];
    logic        b_mosi_seq[$];
    logic        a_prev_sclk = 1'b0, a_prev_ss_n = 1'b1;
    logic [7:0]  er_a, er_b;
    int unsigned ec_a, ec_b;

    // Monitor A: done checks, sclk-rise bookkeeping and the mode-0 slave.
    always @(negedge clk) begin
        if (a_done) begin
            a_done_cnt++;
            if (qa_rx.size() == 0) begin
                check("a_done_expected", 32'd0, 32'd1);
            end else begin
                er_a = qa_rx.pop_front();
                ec_a = qa_cyc.pop_front();
                check("a_rx_data", 32'(a_rx), 32'(er_a));
                check("a_done_cycle", cyc, ec_a);
            end
        end
        if (!a_ss_n && a_sclk && !a_prev_sclk) begin
            a_rises++;
            a_mosi_seq.push_back(a_mosi);
            slv_rx = {slv_rx[6:0], a_mosi};
        end
        if (a_prev_ss_n && !a_ss_n)
            slv_sr = 8'h5A;
        else if (!a_sclk && a_prev_sclk)
            slv_sr = {slv_sr[6:0], 1'b0};
        a_prev_sclk = a_sclk;
        a_prev_ss_n = a_ss_n;
    end

    // Monitor B: done checks and per-cycle sclk/mosi trace while selected.
    always @(negedge clk) begin
        if (b_done) begin
            b_done_cnt++;
            if (qb_rx.size() == 0) begin
                check("b_done_expected", 32'd0, 32'd1);
            end else begin
                er_b = qb_rx.pop_front();
                ec_b = qb_cyc.pop_front();
                check("b_rx_data", 32'(b_rx), 32'(er_b));
                check("b_done_cycle", cyc, ec_b);
            end
        end
        if (!b_ss_n) begin
            b_sclk_seq.push_back(b_sclk);
            b_mosi_seq.push_back(b_mosi);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_a(input logic [7:0] tx, input logic [7:0] exp_rx);
        qa_rx.push_back(exp_rx);
        qa_cyc.push_back(cyc + 37);
        a_tx    = tx;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic wait_done_a(input int unsigned n0);
        for (int i = 0; i < 300; i++) begin
            if (a_done_cnt > n0) return;
            tick();
        end
        check("a_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done_b(input int unsigned n0);
        for (int i = 0; i < 300; i++) begin
            if (b_done_cnt > n0) return;
            tick();
        end
        check("b_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int unsigned n0, r0, m0, s0, c0;
    logic [7:0]  bits8;
    logic [31:0] pat_got, pat_exp;
    bit          hit;

    initial begin
        tick(); tick(); tick();
        check("a_reset_ctrl", 32'({a_sclk, a_ss_n, a_mosi, a_busy, a_done}), 32'b01000);
        check("a_reset_rx", 32'(a_rx), 32'h0);
        check("b_reset_ctrl", 32'({b_sclk, b_ss_n, b_mosi, b_busy, b_done}), 32'b01000);
        a_rst = 1'b0;
        b_rst = 1'b0;
        tick();

        // Loopback 0xAC: latency, rise count, mosi order.
        n0 = a_done_cnt; r0 = a_rises; m0 = a_mosi_seq.size();
        start_a(8'hAC, 8'hAC);
        check("a_busy_after_start", 32'({a_busy, a_ss_n}), 32'b10);
        wait_done_a(n0);
        check("a_sclk_rises", a_rises - r0, 32'd8);
        bits8 = '0;
        if (a_mosi_seq.size() >= m0 + 8)
            for (int i = 0; i < 8; i++) bits8[7-i] = a_mosi_seq[m0+i];
        check("a_mosi_sequence", 32'(bits8), 32'hAC);
        tick();
        check("a_idle_after_done", 32'({a_busy, a_ss_n, a_mosi, a_done}), 32'b0100);

        // Slave model returns 0x5A while master sends 0xFF.
        a_mode = 1'b1;
        n0 = a_done_cnt;
        start_a(8'hFF, 8'h5A);
        wait_done_a(n0);
        check("slave_received", 32'(slv_rx), 32'hFF);
        tick();
        a_mode = 1'b0;

        // CLK_DIV=1: one-cycle sclk phases, done at cycle 19, last bit held.
        n0 = b_done_cnt; s0 = b_sclk_seq.size();
        qb_rx.push_back(8'h01);
        qb_cyc.push_back(cyc + 19);
        b_tx = 8'h01; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_done_b(n0);
        check("b_selected_cycles", b_sclk_seq.size() - s0, 32'd18);
        pat_got = '0; pat_exp = '0;
        for (int i = 0; i < 18; i++) begin
            pat_exp = {pat_exp[30:0], (i >= 1 && i <= 16 && (i % 2) == 1) ? 1'b1 : 1'b0};
            pat_got = {pat_got[30:0], (b_sclk_seq.size() > s0 + i) ? b_sclk_seq[s0+i] : 1'b0};
        end
        check("b_sclk_pattern", pat_got, pat_exp);
        check("b_mosi_in_hold", 32'(b_mosi_seq[b_mosi_seq.size()-1]), 32'd1);
        check("b_mosi_last_low", 32'(b_mosi_seq[b_mosi_seq.size()-2]), 32'd1);

        // Back-to-back with start held high.
        n0 = a_done_cnt; c0 = cyc;
        qa_rx.push_back(8'h12); qa_cyc.push_back(c0 + 37);
        qa_rx.push_back(8'h34); qa_cyc.push_back(c0 + 74);
        a_tx = 8'h12; a_start = 1'b1;
        tick();
        a_tx = 8'h34;
        wait_done_a(n0);
        check("b2b_gap_ss_n_high", 32'(a_ss_n), 32'd1);
        tick();
        check("b2b_reselected", 32'({a_ss_n, a_busy}), 32'b01);
        a_start = 1'b0;
        wait_done_a(n0 + 1);
        check("b2b_done_count", a_done_cnt - n0, 32'd2);

        // Start and tx_data changes while busy are ignored.
        tick();
        n0 = a_done_cnt;
        start_a(8'h3C, 8'h3C);
        repeat (5) tick();
        a_tx = 8'hC3; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (3) tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_done_a(n0);
        repeat (60) tick();
        check("ignore_single_done", a_done_cnt - n0, 32'd1);

        // Reset at the 4th sclk rise aborts cleanly.
        n0 = a_done_cnt; r0 = a_rises;
        a_tx = 8'hAC; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (a_rises - r0 == 4) hit = 1'b1;
            else tick();
        end
        check("rst_reached_4th_rise", 32'(hit), 32'd1);
        a_rst = 1'b1;
        tick();
        check("rst_mid_ctrl", 32'({a_sclk, a_ss_n, a_mosi, a_busy, a_done}), 32'b01000);
        check("rst_mid_rx", 32'(a_rx), 32'h0);
        a_rst = 1'b0;
        repeat (40) tick();
        check("rst_no_done", a_done_cnt - n0, 32'd0);
        start_a(8'h96, 8'h96);
        wait_done_a(n0);
        tick();

        check("a_scoreboard_drained", qa_rx.size(), 32'd0);
        check("b_scoreboard_drained", qb_rx.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
